// File: rtl/seg7_pattern_encoder.sv
// seg7_pattern_encoder: debounce a 7-segment bus and recover its hex nibble; SEG7_ENC_ERRCNT_EN adds an invalid-glyph counter
module seg7_pattern_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [6:0] seg_in,
    output logic [3:0] data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic [7:0] err_count
);
    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
    localparam logic [6:0] BLANK = 7'h7F;
    typedef enum logic [1:0] {TRACK, PRESENT, DONE} state_t;
    state_t state;
    logic [6:0] sync_a, sync_b, cand;
    logic [3:0] cnt, nib;
    logic legal;
    // two-flop synchroniser for the asynchronous segment bus
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync_a <= BLANK;
            sync_b <= BLANK;
        end else begin
            sync_a <= seg_in;
            sync_b <= sync_a;
        end
    end
    // glyph lookup of the stable candidate; illegal glyphs give nibble 0
    always_comb begin
        nib = 4'h0;
        legal = 1'b1;
        case (cand)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end
    // stability tracker and output handshake; cand doubles as the last emitted pattern in DONE
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= TRACK;
            cand <= BLANK;
            cnt <= 4'd0;
            data_out <= 4'h0;
            out_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            case (state)
                TRACK:
                    if (cnt == STABLE && cand != BLANK) begin
                        state <= PRESENT;
                        data_out <= nib;
                        err <= !legal;
                        out_valid <= 1'b1;
                    end else if (sync_b == cand) begin
                        cnt <= (cnt == STABLE) ? cnt : cnt + 4'd1;
                    end else begin
                        cand <= sync_b;
                        cnt <= 4'd1;
                    end
                PRESENT:
                    if (out_ready) begin
                        state <= DONE;
                        out_valid <= 1'b0;
                    end
                default:
                    if (sync_b != cand) begin
                        state <= TRACK;
                        cand <= sync_b;
                        cnt <= 4'd1;
                    end
            endcase
        end
    end
`ifdef SEG7_ENC_ERRCNT_EN
    // saturating count of handshaken invalid glyphs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            err_count <= 8'd0;
        else if (state == PRESENT && out_ready && err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`else
    assign err_count = 8'd0;
`endif
endmodule

// File: doc/seg7_pattern_encoder.md
SEG7_PATTERN_ENCODER -- requirements
Module: seg7_pattern_encoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (legal 1..15): consecutive identical synchronised samples needed to accept a pattern.
REQ-002 SHALL have port CLOCK_50, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port seg_in, input, 7: asynchronous active-low segment bus, bit0=a ... bit6=g, 1 = segment off.
REQ-005 SHALL have port data_out, output, 4: recovered hex nibble.
REQ-006 SHALL have port out_valid, output, 1: data_out/err hold an accepted result.
REQ-007 SHALL have port out_ready, input, 1: consumer accepts the result when high with out_valid.
REQ-008 SHALL have port err, output, 1: the accepted pattern is not a legal hex glyph.
REQ-009 SHALL have port err_count, output, 8: count of accepted invalid patterns (see Configuration).

Function
REQ-010 SHALL pass seg_in through a two-flop synchroniser before any other use.
REQ-011 SHALL map these patterns (hex) to the listed nibbles: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-012 SHALL treat 7F (all segments off) as blank: never emitted, no error, FSM stays in or returns to TRACK.
REQ-013 SHALL treat any other pattern as invalid: emitted with err=1 and data_out=0.
REQ-014 SHALL implement states TRACK, PRESENT and DONE.
REQ-015 TRACK: keep a candidate pattern and a stability count; on a synchronised sample equal to the candidate, increment the count; on a different sample, load it as candidate and set the count to 1.
REQ-016 TRACK -> PRESENT when the count reaches STABLE_CYCLES and the candidate is not 7F; data_out/err are registered and out_valid is set in that cycle.
REQ-017 Latency: with seg_in changing to a constant non-blank pattern just before edge k, out_valid SHALL be high from edge k+2+STABLE_CYCLES.
REQ-018 PRESENT: data_out, err and out_valid SHALL stay constant until out_valid&out_ready is sampled; seg_in changes meanwhile are ignored.
REQ-019 PRESENT -> DONE on handshake; out_valid SHALL be low from the next cycle.
REQ-020 DONE: no emission while the synchronised sample equals the last emitted pattern; on the first differing sample -> TRACK with that sample as candidate and count 1.
REQ-021 out_ready SHALL be ignored outside PRESENT.
REQ-022 A pattern held indefinitely SHALL be emitted exactly once.

Reset
REQ-023 resetn low SHALL immediately force: synchroniser and candidate 7F, count 0, state TRACK, data_out 0, out_valid 0, err 0, err_count 0.
REQ-024 Reset asserted in PRESENT SHALL drop out_valid without a handshake; the pending result is discarded.
REQ-025 After reset release, a result SHALL NOT be emitted until a non-blank pattern is held for the REQ-017 latency.

Configuration
REQ-026 Macro SEG7_ENC_ERRCNT_EN defined: err_count increments by 1 on each handshake with err=1 and saturates at 255.
REQ-027 Macro SEG7_ENC_ERRCNT_EN undefined: err_count SHALL be tied to 0, no counter logic; all other behaviour is identical.

Verification
REQ-028 STABLE_CYCLES=4, out_ready=1; hold seg_in=24 -> out_valid high at edge k+6 for one cycle with data_out=2, err=0; no further pulse while 24 is held.
REQ-029 Sweep all 16 legal patterns, each followed by 7F -> nibbles 0..F in order, err=0, no emission for 7F.
REQ-030 seg_in=7E for 6+ cycles with out_ready=1 -> data_out=0, err=1; with SEG7_ENC_ERRCNT_EN, err_count=1; repeat 300 invalid emissions -> err_count=255.
REQ-031 out_ready=0, apply 12, then change seg_in to 00 while PRESENT -> data_out remains 5; raise out_ready -> handshake, then 8 emitted after 4 stable cycles.
REQ-032 Toggle seg_in between 30 and 19 every 2 cycles with STABLE_CYCLES=4 -> no emission; assert resetn=0 during PRESENT -> out_valid drops at once and all outputs are 0.
